// File: rtl/minimips_pkg.sv
// minimips_pkg: shared defaults for the stream demultiplexer and its buffers
package minimips_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/demux1x2_stream_fifo.sv
// stream_fifo: synchronous FIFO with registered head, power-of-two depth
module stream_fifo
  import minimips_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // accept only when room / data exists; pointers wrap naturally at DEPTH
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rdata = mem_q[rd_q];
  end
  // pointer and occupancy state, reset wins over any transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // storage write on accepted push
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/demux1x2_stream.sv
// demux1x2_stream: steers one input stream into two buffered output ports
module demux1x2_stream
  import minimips_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic full0, full1, empty0, empty1, push0, push1;
  cnt_t cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  // ready follows the selected buffer only; valid/ready of outputs never feed back
  always_comb begin
    in_ready = in_sel ? !full1 : !full0;
    push0 = in_valid && in_ready && !in_sel;
    push1 = in_valid && in_ready && in_sel;
    out0_valid = !empty0;
    out1_valid = !empty1;
    cnt0_d = cnt0_q + cnt_t'(push0);
    cnt1_d = cnt1_q + cnt_t'(push1);
    cnt0 = cnt0_q;
    cnt1 = cnt1_q;
  end
  // accepted-word counters, wrap modulo 256
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset), .push(push0), .pop(out0_ready), .wdata(in_data),
    .full(full0), .empty(empty0), .rdata(out0_data)
  );
  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .push(push1), .pop(out1_ready), .wdata(in_data),
    .full(full1), .empty(empty1), .rdata(out1_data)
  );
endmodule

// File: tb/tb_demux1x2_stream.sv
// tb_demux1x2_stream: randomized and directed checks against a queue model
module tb_demux1x2_stream;
  localparam int W = 32;
  localparam int D = 2;
  logic clk = 0, reset = 0, in_valid = 0, in_sel = 0, out0_ready = 0, out1_ready = 0;
  logic in_ready, out0_valid, out1_valid;
  logic [W-1:0] in_data = '0, out0_data, out1_data;
  logic [7:0] cnt0, cnt1;
  int checks = 0, errors = 0;
  bit armed = 0;
  logic [31:0] q0[$], q1[$], em0[$], em1[$];
  logic [7:0] c0 = 0, c1 = 0;

  demux1x2_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [31:0] d,
                      input logic r0, input logic r1, input logic rst, output bit acc);
    bit rdy, p0, p1;
    reset = rst; in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    rdy = (s ? q1.size() : q0.size()) < D;
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
      if (q0.size() > 0) chk("out0_data", out0_data, q0[0]);
      if (q1.size() > 0) chk("out1_data", out1_data, q1[0]);
      chk("cnt0", 32'(cnt0), 32'(c0));
      chk("cnt1", 32'(cnt1), 32'(c1));
    end
    acc = !rst && v && rdy;
    p0 = !rst && r0 && q0.size() > 0;
    p1 = !rst && r1 && q1.size() > 0;
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete(); c0 = 0; c1 = 0;
    end else begin
      if (p0) em0.push_back(q0.pop_front());
      if (p1) em1.push_back(q1.pop_front());
      if (acc && !s) begin q0.push_back(d); c0++; end
      if (acc && s) begin q1.push_back(d); c1++; end
    end
    @(negedge clk);
    armed = 1;
  endtask

  task automatic idle(input logic r0, input logic r1);
    bit a;
    step(0, 0, 0, r0, r1, 0, a);
  endtask

  task automatic do_reset();
    bit a;
    step(0, 0, 0, 0, 0, 1, a);
    em0.delete(); em1.delete();
  endtask

  task automatic send(input logic s, input logic [31:0] d, input bit rnd, input logic r1fix);
    bit a = 0;
    int n = 0;
    while (!a && n < 50) begin
      step(1, s, d, rnd ? 1'($urandom) : 1'b0, rnd ? 1'($urandom) : r1fix, 0, a);
      n++;
    end
    chk("send_timeout", 32'(a), 32'd1);
  endtask

  initial begin
    bit a;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1, a);
    armed = 0;
    do_reset();
    // single word to port 0
    step(1, 0, 32'hA5A5A5A5, 0, 0, 0, a);
    chk("a5_accept", 32'(a), 32'd1);
    idle(0, 0);
    chk("a5_cnt0_direct", 32'(cnt0), 32'd1);
    idle(1, 0);
    idle(0, 0);
    em0.delete();
    // fill port 0, then port 1 still accepts
    step(1, 0, 32'h1, 0, 0, 0, a);
    step(1, 0, 32'h2, 0, 0, 0, a);
    step(1, 0, 32'h3, 0, 0, 0, a);
    chk("full_reject", 32'(a), 32'd0);
    step(1, 1, 32'h3, 0, 0, 0, a);
    chk("port1_accept", 32'(a), 32'd1);
    // pop while full does not enable push that cycle
    step(1, 0, 32'h4, 1, 0, 0, a);
    chk("pop_no_push", 32'(a), 32'd0);
    step(1, 0, 32'h4, 0, 0, 0, a);
    chk("push_after_pop", 32'(a), 32'd1);
    repeat (4) idle(1, 1);
    chk("order0_n", 32'(em0.size()), 32'd3);
    if (em0.size() == 3) begin
      chk("order0_a", em0[0], 32'h1);
      chk("order0_b", em0[1], 32'h2);
      chk("order0_c", em0[2], 32'h4);
    end
    // alternating select with random readys
    do_reset();
    for (int i = 0; i < 10; i++) send(1'(i), 32'(i), 1, 0);
    repeat (6) idle(1, 1);
    chk("alt_n0", 32'(em0.size()), 32'd5);
    chk("alt_n1", 32'(em1.size()), 32'd5);
    for (int i = 0; i < 5 && i < em0.size() && i < em1.size(); i++) begin
      chk("alt_p0", em0[i], 32'(2 * i));
      chk("alt_p1", em1[i], 32'(2 * i + 1));
    end
    chk("alt_cnt0", 32'(cnt0), 32'd5);
    chk("alt_cnt1", 32'(cnt1), 32'd5);
    // 256 words to port 1, counter wraps
    do_reset();
    for (int i = 0; i < 256; i++) send(1, 32'(i * 7 + 3), 0, 1);
    repeat (4) idle(1, 1);
    chk("wrap_cnt1", 32'(cnt1), 32'd0);
    chk("wrap_n", 32'(em1.size()), 32'd256);
    for (int i = 0; i < em1.size(); i++) if (em1[i] !== 32'(i * 7 + 3)) chk("wrap_order", em1[i], 32'(i * 7 + 3));
    // reset mid-operation with coincident push
    step(1, 0, 32'h11, 0, 0, 0, a);
    step(1, 1, 32'h22, 0, 0, 0, a);
    idle(0, 0);
    step(1, 0, 32'h77, 0, 0, 1, a);
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    idle(1, 1);
    idle(1, 1);
    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 49) == 0, a);
    repeat (4) idle(1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux1x2_stream.md
DEMUX1X2_STREAM -- requirements
Module: demux1x2_stream

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits.
REQ-002 Parameter DEPTH, default 2, entries per output buffer (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 in_sel  input  1  destination: 0 selects port 0, 1 selects port 1.
REQ-009 out0_valid / out1_valid  output  1  port holds a word.
REQ-010 out0_ready / out1_ready  input  1  downstream consumes the word.
REQ-011 out0_data / out1_data  output  WIDTH  head word of the port buffer.
REQ-012 cnt0 / cnt1  output  8  words accepted for port 0 / port 1, modulo 256.

Function
REQ-013 Transfer in: in_valid && in_ready on a rising edge pushes in_data into the buffer chosen by in_sel; in_data and in_sel are sampled only on that edge.
REQ-014 in_ready SHALL equal !full of the buffer selected by the current in_sel; it is combinational, never depends on in_valid, and never depends on out*_ready.
REQ-015 Latency: a word pushed into an empty buffer SHALL appear with outN_valid=1 on the cycle after the push edge; no same-cycle bypass.
REQ-016 Transfer out: outN_valid && outN_ready on an edge pops the head; outN_data SHALL be the head word whenever outN_valid=1 and is don't-care otherwise.
REQ-017 Each port buffer is first-in first-out; word order within a port is preserved; the two ports are fully independent.
REQ-018 Simultaneous push and pop on the same non-empty, non-full buffer SHALL leave occupancy unchanged and preserve order.
REQ-019 Full buffer: the selected in_ready=0, no push; a pop in the same cycle does not enable a push that cycle (in_ready asserts the following cycle).
REQ-020 Empty buffer: outN_ready is ignored; no pop, occupancy stays 0.
REQ-021 A push to one port and a pop from the other in the same cycle SHALL both complete.
REQ-022 Read/write pointers wrap from DEPTH-1 to 0; occupancy counts 0..DEPTH.
REQ-023 cnt0/cnt1 SHALL increment by 1 on each accepted word for that port, wrap 255->0, and never change on pops.
REQ-024 No word is dropped or duplicated under any valid/ready pattern.

Reset
REQ-025 With reset=1 on an edge: both buffers empty, pointers 0, cnt0=cnt1=0, out0_valid=out1_valid=0.
REQ-026 in_ready SHALL read 1 from the first cycle after reset deasserts.
REQ-027 Reset mid-operation SHALL discard all buffered words, with no pop reported and any coincident push ignored; reset has priority over all transfers.
REQ-028 out*_data after reset is don't-care; benches shall check it only while valid=1.

Structure
REQ-029 Shared package minimips_pkg holds the default WIDTH (32), DEPTH (2) and the counter width (8).
REQ-030 One sub-module, stream_fifo: a parameterised synchronous FIFO (push, pop, full, empty, head data), instantiated once per port.
REQ-031 Top level holds only the in_sel steering, the in_ready mux and the two counters.

Verification
REQ-032 Reset, then in_sel=0 with 0xA5A5A5A5 for one cycle -> out0_valid=1 next cycle, out0_data=0xA5A5A5A5, cnt0=1, out1_valid=0.
REQ-033 out0_ready=0; push 0x1, 0x2 to port 0 -> in_ready=0 while in_sel=0 and 1 while in_sel=1; a third push to port 1 is accepted with cnt1=1.
REQ-034 Port 0 full, out0_ready=1 for one cycle with in_valid=1 and in_sel=0 -> pop of 0x1 only; push accepted the next cycle; order 0x2 then the new word.
REQ-035 Alternate in_sel 0/1 with data 0..9, both readys toggling pseudo-randomly -> port 0 emits 0,2,4,6,8; port 1 emits 1,3,5,7,9; cnt0=cnt1=5.
REQ-036 Push 256 words to port 1 with out1_ready=1 -> cnt1 wraps to 0; all 256 words emerge in order.
REQ-037 Both buffers hold words, assert reset for one cycle with in_valid=1 -> out0_valid=out1_valid=0, cnt0=cnt1=0, and the coincident word is not stored.
